// File: rtl/game_flow_pkg.sv
// rtl/game_flow_pkg.sv - shared state encodings, colour constants and width helper for the game flow controller
package game_flow_pkg;

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_CLEAR = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    // Colour constants are single bits replicated to COLOR_W by the users,
    // so the package does not depend on the colour width parameter.
    localparam logic WHITE_BIT = 1'b1;
    localparam logic BLACK_BIT = 1'b0;

    // Level register width; a single level still needs one bit.
    function automatic int lvl_w(input int num_levels);
        return (num_levels <= 2) ? 1 : $clog2(num_levels);
    endfunction

endpackage

// File: rtl/level_marker_overlay.sv
// rtl/level_marker_overlay.sv - combinational level-select marker hit test and marker colour
//
// Ports:
//   x, y    in  current pixel coordinate
//   level   in  cursor level (selected marker is drawn white)
//   hit     out pixel lies inside some marker square
//   colour  out marker colour (all-ones for the cursor marker, else all-zeros)
module level_marker_overlay
    import game_flow_pkg::*;
#(
    parameter int NUM_LEVELS = 3,
    parameter int COLOR_W    = 12,
    parameter int COORD_W    = 10,
    parameter int MARK_X0    = 251,
    parameter int MARK_Y0    = 200,
    parameter int MARK_PITCH = 36,
    parameter int MARK_SIZE  = 7,
    parameter int LVL_W      = lvl_w(NUM_LEVELS)
) (
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [LVL_W-1:0]   level,
    output logic               hit,
    output logic [COLOR_W-1:0] colour
);

    // Bounds are one bit wider than the coordinates so a marker near the
    // screen edge never wraps around to low coordinates.
    localparam logic [COORD_W:0] X_LO = (COORD_W+1)'(MARK_X0);
    localparam logic [COORD_W:0] X_HI = (COORD_W+1)'(MARK_X0 + MARK_SIZE - 1);

    logic [COORD_W:0] x_ext;
    logic [COORD_W:0] y_ext;
    logic             x_in;

    assign x_ext = {1'b0, x};
    assign y_ext = {1'b0, y};
    assign x_in  = (x_ext >= X_LO) && (x_ext <= X_HI);

    always_comb begin
        hit    = 1'b0;
        colour = {COLOR_W{BLACK_BIT}};
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (x_in
                && (y_ext >= (COORD_W+1)'(MARK_Y0 + i*MARK_PITCH))
                && (y_ext <= (COORD_W+1)'(MARK_Y0 + i*MARK_PITCH + MARK_SIZE - 1))) begin
                hit = 1'b1;
                if (level == LVL_W'(i)) begin
                    colour = {COLOR_W{WHITE_BIT}};
                end
            end
        end
    end

endmodule

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - game screen sequencer, level menu/advance and per-screen pixel colour mux
//
// Ports:
//   clk, resetn                        clock, synchronous active-low reset
//   select_p, up_p, down_p, pause_p    debounced single-cycle button pulses
//   frame_tick                         one pulse per frame
//   game_over, level_clear             game core status (level / pulse)
//   x, y                               current pixel coordinate
//   colour_start/play/over             screen source colours
//   state, level                       current screen and cursor/active level
//   start_en, play_en, over_en         screen source enables
//   game_rst_n                         one-cycle low pulse at every level start
//   won                                final level cleared
//   colour_out                         registered pixel colour
module game_flow_ctrl
    import game_flow_pkg::*;
#(
    parameter int NUM_LEVELS   = 3,
    parameter int COLOR_W      = 12,
    parameter int COORD_W      = 10,
    parameter int MARK_X0      = 251,
    parameter int MARK_Y0      = 200,
    parameter int MARK_PITCH   = 36,
    parameter int MARK_SIZE    = 7,
    parameter int CLEAR_FRAMES = 60,
    localparam int LVL_W       = lvl_w(NUM_LEVELS)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               select_p,
    input  logic               up_p,
    input  logic               down_p,
    input  logic               pause_p,
    input  logic               frame_tick,
    input  logic               game_over,
    input  logic               level_clear,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [COLOR_W-1:0] colour_start,
    input  logic [COLOR_W-1:0] colour_play,
    input  logic [COLOR_W-1:0] colour_over,
    output logic [2:0]         state,
    output logic [LVL_W-1:0]   level,
    output logic               start_en,
    output logic               play_en,
    output logic               over_en,
    output logic               game_rst_n,
    output logic               won,
    output logic [COLOR_W-1:0] colour_out
);

    localparam int CNT_W = $clog2(CLEAR_FRAMES + 1);
    localparam int CH_W  = COLOR_W / 3;

    state_t             state_q, state_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               won_q, won_d;
    logic               game_rst_n_q, game_rst_n_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [COLOR_W-1:0] colour_q, colour_d;

    logic               last_level;
    logic               clear_done;
    logic               mark_hit;
    logic [COLOR_W-1:0] mark_colour;
    logic [COLOR_W-1:0] colour_dim;

    assign last_level = (level_q == LVL_W'(NUM_LEVELS - 1));
    // The tick that ends the hold is the CLEAR_FRAMES-th one seen in CLEAR.
    assign clear_done = (state_q == ST_CLEAR) && frame_tick
                        && (cnt_q == CNT_W'(CLEAR_FRAMES - 1));

    // Screen sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_START: if (select_p) state_d = ST_PLAY;
            ST_PLAY: begin
                if (game_over)        state_d = ST_OVER;
                else if (level_clear) state_d = ST_CLEAR;
                else if (pause_p)     state_d = ST_PAUSE;
            end
            ST_PAUSE: if (pause_p || select_p) state_d = ST_PLAY;
            ST_CLEAR: if (clear_done) state_d = last_level ? ST_OVER : ST_PLAY;
            ST_OVER:  if (select_p) state_d = ST_START;
            default:  state_d = ST_START;
        endcase
    end

    // Level cursor, win flag, clear-hold counter and game core reset pulse
    always_comb begin
        level_d      = level_q;
        won_d        = won_q;
        cnt_d        = cnt_q;
        game_rst_n_d = 1'b1;
        case (state_q)
            ST_START: begin
                if (select_p) begin
                    won_d        = 1'b0;
                    game_rst_n_d = 1'b0;
                end else if (down_p && !up_p) begin
                    level_d = last_level ? '0 : level_q + 1'b1;
                end else if (up_p && !down_p) begin
                    level_d = (level_q == '0) ? LVL_W'(NUM_LEVELS - 1) : level_q - 1'b1;
                end
            end
            ST_PLAY: if (!game_over && level_clear) cnt_d = '0;
            ST_CLEAR: begin
                if (clear_done) begin
                    if (last_level) begin
                        won_d = 1'b1;
                    end else begin
                        level_d      = level_q + 1'b1;
                        game_rst_n_d = 1'b0;
                    end
                end else if (frame_tick) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    level_marker_overlay #(
        .NUM_LEVELS (NUM_LEVELS),
        .COLOR_W    (COLOR_W),
        .COORD_W    (COORD_W),
        .MARK_X0    (MARK_X0),
        .MARK_Y0    (MARK_Y0),
        .MARK_PITCH (MARK_PITCH),
        .MARK_SIZE  (MARK_SIZE),
        .LVL_W      (LVL_W)
    ) u_marker (
        .x      (x),
        .y      (y),
        .level  (level_q),
        .hit    (mark_hit),
        .colour (mark_colour)
    );

    // Pause dimming halves each colour channel independently.
    always_comb begin
        colour_dim = '0;
        for (int c = 0; c < 3; c++) begin
            colour_dim[c*CH_W +: CH_W] = colour_play[c*CH_W +: CH_W] >> 1;
        end
    end

    always_comb begin
        colour_d = colour_play;
        case (state_q)
            ST_START: colour_d = mark_hit ? mark_colour : colour_start;
            ST_PAUSE: colour_d = colour_dim;
            ST_OVER:  colour_d = colour_over;
            default:  colour_d = colour_play;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= ST_START;
            level_q      <= '0;
            won_q        <= 1'b0;
            game_rst_n_q <= 1'b0;
            cnt_q        <= '0;
            colour_q     <= '0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            won_q        <= won_d;
            game_rst_n_q <= game_rst_n_d;
            cnt_q        <= cnt_d;
            colour_q     <= colour_d;
        end
    end

    assign state      = state_q;
    assign level      = level_q;
    assign won        = won_q;
    assign game_rst_n = game_rst_n_q;
    assign colour_out = colour_q;
    assign start_en   = (state_q == ST_START);
    assign play_en    = (state_q == ST_PLAY);
    assign over_en    = (state_q == ST_OVER);

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - self-checking bench for game_flow_ctrl with a behavioural reference model
module tb_game_flow_ctrl;

    localparam int N  = 3;
    localparam int CF = 2;
    localparam int X0 = 251;
    localparam int Y0 = 200;
    localparam int P  = 36;
    localparam int S  = 7;

    logic        clk = 1'b0;
    logic        resetn, select_p, up_p, down_p, pause_p;
    logic        frame_tick, game_over, level_clear;
    logic [9:0]  x, y;
    logic [11:0] colour_start, colour_play, colour_over;
    logic [2:0]  state;
    logic [1:0]  level;
    logic        start_en, play_en, over_en, game_rst_n, won;
    logic [11:0] colour_out;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          m_st, m_lvl, m_won, m_grn, m_ticks;
    logic [11:0] m_col;

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .NUM_LEVELS   (N),
        .COLOR_W      (12),
        .COORD_W      (10),
        .MARK_X0      (X0),
        .MARK_Y0      (Y0),
        .MARK_PITCH   (P),
        .MARK_SIZE    (S),
        .CLEAR_FRAMES (CF)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .select_p     (select_p),
        .up_p         (up_p),
        .down_p       (down_p),
        .pause_p      (pause_p),
        .frame_tick   (frame_tick),
        .game_over    (game_over),
        .level_clear  (level_clear),
        .x            (x),
        .y            (y),
        .colour_start (colour_start),
        .colour_play  (colour_play),
        .colour_over  (colour_over),
        .state        (state),
        .level        (level),
        .start_en     (start_en),
        .play_en      (play_en),
        .over_en      (over_en),
        .game_rst_n   (game_rst_n),
        .won          (won),
        .colour_out   (colour_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pixel colour the screen should show for a given screen number.
    function automatic logic [11:0] exp_colour(input int st, input int xx, input int yy, input int lvl);
        logic [11:0] r;
        int idx;
        r = colour_play;
        if (st == 0) begin
            r = colour_start;
            if (xx >= X0 && xx <= X0 + S - 1 && yy >= Y0) begin
                idx = (yy - Y0) / P;
                if (idx < N && (yy - Y0) % P < S) r = (idx == lvl) ? 12'hFFF : 12'h000;
            end
        end else if (st == 2) begin
            r = 12'((int'(colour_play[11:8]) / 2) * 256 + (int'(colour_play[7:4]) / 2) * 16
                    + int'(colour_play[3:0]) / 2);
        end else if (st == 4) begin
            r = colour_over;
        end
        return r;
    endfunction

    task automatic model_step();
        int nst;
        if (!resetn) begin
            m_st = 0; m_lvl = 0; m_won = 0; m_grn = 0; m_ticks = 0; m_col = '0;
            return;
        end
        m_col = exp_colour(m_st, int'(x), int'(y), m_lvl);
        m_grn = 1;
        nst   = m_st;
        case (m_st)
            0: if (select_p) begin
                   nst = 1; m_won = 0; m_grn = 0;
               end else if (up_p != down_p) begin
                   m_lvl = down_p ? (m_lvl + 1) % N : (m_lvl + N - 1) % N;
               end
            1: if (game_over) nst = 4;
               else if (level_clear) begin nst = 3; m_ticks = 0; end
               else if (pause_p) nst = 2;
            2: if (pause_p || select_p) nst = 1;
            3: if (frame_tick) begin
                   m_ticks++;
                   if (m_ticks == CF) begin
                       if (m_lvl < N - 1) begin m_lvl++; nst = 1; m_grn = 0; end
                       else begin m_won = 1; nst = 4; end
                   end
               end
            4: if (select_p) nst = 0;
            default: ;
        endcase
        m_st = nst;
    endtask

    task automatic check_model();
        chk("state", 32'(state), 32'(m_st));
        chk("level", 32'(level), 32'(m_lvl));
        chk("won", 32'(won), 32'(m_won));
        chk("game_rst_n", 32'(game_rst_n), 32'(m_grn));
        chk("start_en", 32'(start_en), 32'(m_st == 0));
        chk("play_en", 32'(play_en), 32'(m_st == 1));
        chk("over_en", 32'(over_en), 32'(m_st == 4));
        chk("colour_out", 32'(colour_out), 32'(m_col));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_model();
        select_p = 0; up_p = 0; down_p = 0; pause_p = 0;
        frame_tick = 0; level_clear = 0; game_over = 0;
        @(negedge clk);
    endtask

    initial begin
        resetn = 0; select_p = 0; up_p = 0; down_p = 0; pause_p = 0;
        frame_tick = 0; game_over = 0; level_clear = 0;
        x = 0; y = 0;
        colour_start = 12'h123; colour_play = 12'h456; colour_over = 12'h789;
        m_st = 0; m_lvl = 0; m_won = 0; m_grn = 0; m_ticks = 0; m_col = '0;
        @(negedge clk);

        // reset values
        tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_grn", 32'(game_rst_n), 0);
        chk("rst_colour", 32'(colour_out), 0);
        resetn = 1;
        tick();
        chk("grn_after_rst", 32'(game_rst_n), 1);

        // menu wrap
        down_p = 1; tick(); chk("down1", 32'(level), 1);
        down_p = 1; tick(); chk("down2", 32'(level), 2);
        down_p = 1; tick(); chk("down3_wrap", 32'(level), 0);
        up_p = 1;   tick(); chk("up_wrap", 32'(level), 2);
        down_p = 1; tick();
        down_p = 1; tick(); chk("to_lvl1", 32'(level), 1);
        up_p = 1; down_p = 1; tick(); chk("up_down_same", 32'(level), 1);

        // select with a simultaneous down: select wins
        select_p = 1; down_p = 1; x = 254; y = 236; tick();
        chk("sel_state", 32'(state), 1);
        chk("sel_level", 32'(level), 1);
        chk("sel_grn_low", 32'(game_rst_n), 0);
        tick();
        chk("sel_grn_high", 32'(game_rst_n), 1);

        // pause dimming
        colour_play = 12'hF84;
        pause_p = 1; tick();
        chk("pause_state", 32'(state), 2);
        chk("pause_play_en", 32'(play_en), 0);
        game_over = 1; tick();
        chk("pause_dim", 32'(colour_out), 32'h742);
        chk("pause_ignores_over", 32'(state), 2);
        pause_p = 1; tick();
        chk("unpause_state", 32'(state), 1);
        chk("unpause_no_rst", 32'(game_rst_n), 1);

        // level clear and advance
        level_clear = 1; tick(); chk("clear_enter", 32'(state), 3);
        frame_tick = 1;  tick(); chk("clear_tick1", 32'(state), 3);
        frame_tick = 1;  tick();
        chk("clear_adv_lvl", 32'(level), 2);
        chk("clear_adv_state", 32'(state), 1);
        chk("clear_adv_grn", 32'(game_rst_n), 0);
        level_clear = 1; frame_tick = 1; tick(); chk("clear2_enter", 32'(state), 3);
        frame_tick = 1;  tick(); chk("clear2_tick1", 32'(state), 3);
        frame_tick = 1;  tick();
        chk("final_won", 32'(won), 1);
        chk("final_state", 32'(state), 4);

        // back to menu, markers
        select_p = 1; tick(); chk("over_to_start", 32'(state), 0);
        chk("over_keeps_lvl", 32'(level), 2);
        down_p = 1; tick(); chk("lvl0", 32'(level), 0);
        x = 251; y = 200; tick(); chk("marker0_white", 32'(colour_out), 32'hFFF);
        y = 236; tick(); chk("marker1_black", 32'(colour_out), 32'h000);
        select_p = 1; tick(); chk("won_cleared", 32'(won), 0);
        game_over = 1; level_clear = 1; tick();
        chk("over_prio_state", 32'(state), 4);
        chk("over_prio_won", 32'(won), 0);

        // reset in the middle of a clear hold
        select_p = 1; tick();
        select_p = 1; tick();
        level_clear = 1; tick();
        frame_tick = 1; tick();
        resetn = 0; tick();
        chk("midrst_state", 32'(state), 0);
        resetn = 1; tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            resetn       = ($urandom_range(0, 199) != 0);
            select_p     = ($urandom_range(0, 7) == 0);
            up_p         = ($urandom_range(0, 5) == 0);
            down_p       = ($urandom_range(0, 5) == 0);
            pause_p      = ($urandom_range(0, 7) == 0);
            frame_tick   = ($urandom_range(0, 2) == 0);
            game_over    = ($urandom_range(0, 39) == 0);
            level_clear  = ($urandom_range(0, 9) == 0);
            colour_start = 12'($urandom);
            colour_play  = 12'($urandom);
            colour_over  = 12'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                x = 10'($urandom); y = 10'($urandom);
            end else begin
                x = 10'(245 + $urandom_range(0, 18));
                y = 10'(195 + $urandom_range(0, 120));
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
